// File: rtl/regfile_arb_pkg.sv
// Shared defaults and constants for the register-file write arbiter.
package regfile_arb_pkg;

    localparam int NREQ_DEFAULT  = 4;
    localparam int AW_DEFAULT    = 5;
    localparam int DW_DEFAULT    = 32;

    // Register 0 is hardwired; writes to it are acknowledged but discarded.
    localparam int REG_ZERO_ADDR = 0;

endpackage

// File: rtl/rr_pointer_arbiter.sv
// Round-robin arbiter: the pointer holds the highest-priority requester and
// moves to the one after the winner on every grant.
module rr_pointer_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gidx;
    logic          found;
    int            pos;

    // Scan positions ptr, ptr+1, ... (mod NREQ); the first live request wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = (int'(ptr_q) + k) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!found && en && req[i] && (i == pos)) begin
                    grant[i] = 1'b1;
                    gidx     = PW'(i);
                    found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates N write requesters onto one register-file write port with a
// registered output stage. Optional read bypass: define REGFILE_ARB_BYPASS_EN.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int AW   = AW_DEFAULT,
    parameter int DW   = DW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    ack,
    input  logic               wr_ready,
    output logic               wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [DW-1:0]      wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic               rd_hit,
    output logic [DW-1:0]      rd_data
);

    logic [NREQ-1:0] grant;
    logic            arb_en;
    logic            granted;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;

    // Gating with rst_n keeps ack low for the whole reset window, not just at edges.
    assign arb_en = wr_ready & rst_n;

    rr_pointer_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .en    (arb_en),
        .grant (grant)
    );

    assign ack     = grant;
    assign granted = |grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | req_addr[i*AW +: AW];
                sel_data = sel_data | req_data[i*DW +: DW];
            end
        end
    end

    // A dropped register-0 write leaves the held address/data untouched.
    always_comb begin
        wr_en_d   = granted && (sel_addr != AW'(REG_ZERO_ADDR));
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (wr_en_d) begin
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

`ifdef REGFILE_ARB_BYPASS_EN
    assign rd_hit  = wr_en_q && (wr_addr_q == rd_addr) && (rd_addr != AW'(REG_ZERO_ADDR));
    assign rd_data = rd_hit ? wr_data_q : '0;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_hit         = 1'b0;
    assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Table-driven bench for regfile_write_arbiter with an output-stage scoreboard.
module tb_regfile_write_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam logic [19:0] A_DEF = {5'd4, 5'd3, 5'd2, 5'd1};

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    ack;
    logic               wr_ready;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic [AW-1:0]      rd_addr;
    logic               rd_hit;
    logic [DW-1:0]      rd_data;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .ack      (ack),
        .wr_ready (wr_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_hit   (rd_hit),
        .rd_data  (rd_data)
    );

    typedef struct {
        logic [3:0]  req;
        logic        rdy;
        logic [19:0] addr;
        logic [31:0] data;
        logic [3:0]  exp_ack;
    } vec_t;

    typedef struct {
        logic        en;
        logic        chk_ad;
        logic [4:0]  addr;
        logic [31:0] data;
    } out_t;

    vec_t tv[$];
    out_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_known;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic rdy, input logic [19:0] a,
                                input logic [31:0] d, input logic [3:0] e);
        vec_t v;
        v.req = r; v.rdy = rdy; v.addr = a; v.data = d; v.exp_ack = e;
        return v;
    endfunction

    task automatic check_out(input string tag);
        out_t o;
        logic exp_hit;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        o = sbq.pop_front();
        check({tag, " wr_en"}, {31'b0, wr_en}, {31'b0, o.en});
        if (o.chk_ad) begin
            check({tag, " wr_addr"}, {27'b0, wr_addr}, {27'b0, o.addr});
            check({tag, " wr_data"}, wr_data, o.data);
        end
`ifdef REGFILE_ARB_BYPASS_EN
        exp_hit = o.en && (o.addr == rd_addr) && (rd_addr != 5'd0);
`else
        exp_hit = 1'b0;
`endif
        check({tag, " rd_hit"}, {31'b0, rd_hit}, {31'b0, exp_hit});
        check({tag, " rd_data"}, rd_data, exp_hit ? o.data : 32'h0);
    endtask

    task automatic apply(input vec_t v, input int n);
        out_t o;
        int   g;
        string tag;
        tag = $sformatf("vec%0d", n);
        @(negedge clk);
        req      = v.req;
        wr_ready = v.rdy;
        req_addr = v.addr;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = v.data + 32'(i);
        #1;
        check({tag, " ack"}, {28'b0, ack}, {28'b0, v.exp_ack});
        g = -1;
        for (int i = 0; i < NREQ; i++) if (v.exp_ack[i]) g = i;
        o.en = 1'b0; o.chk_ad = m_known; o.addr = m_addr; o.data = m_data;
        if (g >= 0) begin
            if (v.addr[g*AW +: AW] != 5'd0) begin
                o.en = 1'b1; o.chk_ad = 1'b1;
                o.addr = v.addr[g*AW +: AW];
                o.data = v.data + 32'(g);
                m_known = 1'b1; m_addr = o.addr; m_data = o.data;
            end else begin
                o.chk_ad = 1'b0;
                m_known  = 1'b0;
            end
        end
        sbq.push_back(o);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = 4'hF;
        wr_ready = 1'b1;
        req_addr = A_DEF;
        req_data = '0;
        rd_addr  = 5'd5;
        m_addr   = '0;
        m_data   = '0;
        m_known  = 1'b1;

        #2;
        check("rst ack", {28'b0, ack}, 32'h0);
        check("rst wr_en", {31'b0, wr_en}, 32'h0);
        check("rst wr_addr", {27'b0, wr_addr}, 32'h0);
        check("rst wr_data", wr_data, 32'h0);
        check("rst rd_hit", {31'b0, rd_hit}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst ack held", {28'b0, ack}, 32'h0);
        check("rst wr_en held", {31'b0, wr_en}, 32'h0);
        @(negedge clk);
        req = 4'h0;
        #1 rst_n = 1'b1;

        for (int k = 0; k < 8; k++)
            tv.push_back(mk(4'hF, 1'b1, A_DEF, 32'h1000_0000 + 32'(k) * 32'h100, 4'(1 << (k % 4))));
        tv.push_back(mk(4'b0000, 1'b1, A_DEF, 32'h2000_0000, 4'b0000));
        tv.push_back(mk(4'b1010, 1'b1, A_DEF, 32'h2100_0000, 4'b0010));
        tv.push_back(mk(4'b1010, 1'b1, A_DEF, 32'h2200_0000, 4'b1000));
        tv.push_back(mk(4'b1010, 1'b1, A_DEF, 32'h2300_0000, 4'b0010));
        for (int k = 0; k < 3; k++)
            tv.push_back(mk(4'b0100, 1'b0, A_DEF, 32'h3000_0000 + 32'(k) * 32'h100, 4'b0000));
        tv.push_back(mk(4'b0100, 1'b1, A_DEF, 32'h3100_0000, 4'b0100));
        tv.push_back(mk(4'b0011, 1'b1, A_DEF, 32'h3200_0000, 4'b0001));
        tv.push_back(mk(4'b0010, 1'b1, {5'd4, 5'd3, 5'd0, 5'd1}, 32'hDEAD_BEEE, 4'b0010));
        tv.push_back(mk(4'b0001, 1'b1, {5'd4, 5'd3, 5'd2, 5'd5}, 32'h1234_5678, 4'b0001));
        tv.push_back(mk(4'b0000, 1'b1, A_DEF, 32'h4000_0000, 4'b0000));
        tv.push_back(mk(4'b1100, 1'b1, {5'd7, 5'd7, 5'd2, 5'd1}, 32'h5000_0000, 4'b0100));
        tv.push_back(mk(4'b1100, 1'b1, {5'd7, 5'd7, 5'd2, 5'd1}, 32'h5100_0000, 4'b1000));
        tv.push_back(mk(4'b1111, 1'b1, A_DEF, 32'h6000_0000, 4'b0001));

        foreach (tv[n]) apply(tv[n], n);

        // Reset lands mid-cycle while a write is on the port; output must clear at once.
        #2 rst_n = 1'b0;
        #1;
        check("midrst wr_en", {31'b0, wr_en}, 32'h0);
        check("midrst ack", {28'b0, ack}, 32'h0);
        check("midrst wr_addr", {27'b0, wr_addr}, 32'h0);
        check("midrst wr_data", wr_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-rst ack", {28'b0, ack}, 32'h1);
        @(posedge clk);
        #1;
        check("post-rst wr_en", {31'b0, wr_en}, 32'h1);
        check("post-rst wr_addr", {27'b0, wr_addr}, 32'h1);
        check("post-rst wr_data", wr_data, 32'h6000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
